// File: rtl/lfsr_scrambler_if.sv
// AXI-Stream bundle for lfsr_scrambler: data, sideband, frame end and handshake.
interface lfsr_scrambler_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned USER_WIDTH = 4
);
  logic [WIDTH-1:0]      tdata;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, tuser, tvalid, tlast, input  tready);
  modport slave  (input  tdata, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/lfsr_scrambler.sv
// Additive AXI-Stream scrambler/descrambler: Fibonacci LFSR keystream with seed load,
// per-frame reseed, per-beat bypass, tail masking and a 2-entry registered-ready skid.
module lfsr_scrambler #(
  parameter int unsigned         WIDTH          = 32,
  parameter int unsigned         USER_WIDTH     = 4,
  parameter int unsigned         LFSR_LEN       = 7,
  parameter logic [LFSR_LEN-1:0] POLY           = 7'b1001000,
  parameter logic [LFSR_LEN-1:0] SEED           = {LFSR_LEN{1'b1}},
  parameter bit                  RESEED_ON_LAST = 1'b1,
  parameter int unsigned         TAIL_BITS      = 7
) (
  input  logic                aclk,
  input  logic                aresetn,
  lfsr_scrambler_if.slave     s_axis,
  lfsr_scrambler_if.master    m_axis,
  input  logic [LFSR_LEN-1:0] cfg_seed,
  input  logic                cfg_seed_load,
  input  logic                cfg_bypass
);

  function automatic logic [WIDTH-1:0] tail_mask_f();
    logic [WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < WIDTH; i++) m[i] = (i + TAIL_BITS >= WIDTH);
    return m;
  endfunction

  localparam logic [WIDTH-1:0] TAIL_MASK = tail_mask_f();

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} occ_e;

  occ_e                  state_q, state_d;
  logic                  ready_q;
  logic [LFSR_LEN-1:0]   lfsr_q, lfsr_d;
  logic [WIDTH-1:0]      out_data_q, skid_data_q;
  logic [USER_WIDTH-1:0] out_user_q, skid_user_q;
  logic                  out_last_q, skid_last_q;

  logic                      accept, take;
  logic                      load_out, load_skid, skid_to_out;
  logic [LFSR_LEN+WIDTH-1:0] seq;
  logic [WIDTH-1:0]          key, beat_data;

  assign accept = s_axis.tvalid & ready_q;
  assign take   = m_axis.tready & (state_q != ST_EMPTY);

  // seq holds the current state followed by WIDTH freshly generated sequence bits
  always_comb begin
    seq = '0;
    seq[LFSR_LEN-1:0] = lfsr_q;
    for (int unsigned j = LFSR_LEN; j < LFSR_LEN + WIDTH; j++) begin
      for (int unsigned t = 1; t <= LFSR_LEN; t++) begin
        if (POLY[t-1]) seq[j] = seq[j] ^ seq[j-t];
      end
    end
  end

  assign key = seq[LFSR_LEN +: WIDTH];

  always_comb begin
    beat_data = s_axis.tdata;
    if (!cfg_bypass) begin
      beat_data = s_axis.tdata ^ key;
      if (s_axis.tlast) beat_data = beat_data & ~TAIL_MASK;
    end
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (cfg_seed_load)                              lfsr_d = cfg_seed;
    else if (accept && s_axis.tlast && RESEED_ON_LAST) lfsr_d = cfg_seed;
    else if (accept && !cfg_bypass)                 lfsr_d = seq[WIDTH +: LFSR_LEN];
  end

  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          load_out = 1'b1;
          state_d  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && take) begin
          load_out = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end else if (take) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (take) begin
          skid_to_out = 1'b1;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_FULL);
      lfsr_q  <= lfsr_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_data_q  <= '0;
      out_user_q  <= '0;
      out_last_q  <= 1'b0;
      skid_data_q <= '0;
      skid_user_q <= '0;
      skid_last_q <= 1'b0;
    end else begin
      if (load_out) begin
        out_data_q <= beat_data;
        out_user_q <= s_axis.tuser;
        out_last_q <= s_axis.tlast;
      end else if (skid_to_out) begin
        out_data_q <= skid_data_q;
        out_user_q <= skid_user_q;
        out_last_q <= skid_last_q;
      end
      if (load_skid) begin
        skid_data_q <= beat_data;
        skid_user_q <= s_axis.tuser;
        skid_last_q <= s_axis.tlast;
      end
    end
  end

  assign s_axis.tready = ready_q;
  assign m_axis.tvalid = (state_q != ST_EMPTY);
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tuser  = out_user_q;
  assign m_axis.tlast  = out_last_q;

endmodule

// File: tb/tb_lfsr_scrambler.sv
// Bench for lfsr_scrambler: directed vector tables on 8-bit instances, handshake corner
// sequences, and a random round trip through two default instances in series.
module tb_lfsr_scrambler;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic aresetn;

  lfsr_scrambler_if #(.WIDTH(8),  .USER_WIDTH(4)) sa (), ma (), sb (), mb ();
  lfsr_scrambler_if #(.WIDTH(32), .USER_WIDTH(4)) sc (), mid (), mc ();

  logic [6:0] cfg_seed, c_seed;
  logic       cfg_load, cfg_byp, c_load, c_byp;

  lfsr_scrambler #(.WIDTH(8), .USER_WIDTH(4), .LFSR_LEN(7), .POLY(7'b1001000), .SEED(7'h7F),
                   .RESEED_ON_LAST(1'b0), .TAIL_BITS(0)) u_a (
    .aclk(aclk), .aresetn(aresetn), .s_axis(sa), .m_axis(ma),
    .cfg_seed(cfg_seed), .cfg_seed_load(cfg_load), .cfg_bypass(cfg_byp));

  lfsr_scrambler #(.WIDTH(8), .USER_WIDTH(4), .LFSR_LEN(7), .POLY(7'b1001000), .SEED(7'h7F),
                   .RESEED_ON_LAST(1'b1), .TAIL_BITS(0)) u_b (
    .aclk(aclk), .aresetn(aresetn), .s_axis(sb), .m_axis(mb),
    .cfg_seed(cfg_seed), .cfg_seed_load(cfg_load), .cfg_bypass(cfg_byp));

  lfsr_scrambler u_c1 (
    .aclk(aclk), .aresetn(aresetn), .s_axis(sc), .m_axis(mid),
    .cfg_seed(c_seed), .cfg_seed_load(c_load), .cfg_bypass(c_byp));

  lfsr_scrambler u_c2 (
    .aclk(aclk), .aresetn(aresetn), .s_axis(mid), .m_axis(mc),
    .cfg_seed(c_seed), .cfg_seed_load(c_load), .cfg_bypass(c_byp));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Reference keystream: history of sequence bits, oldest first, extended by the tap rule
  localparam logic [6:0] POLY_M = 7'b1001000;
  bit hist[$];

  function automatic void model_seed(input logic [6:0] sd);
    hist = {};
    for (int k = 0; k < 7; k++) hist.push_back(sd[k]);
  endfunction

  function automatic logic [31:0] model_key(input int w);
    logic [31:0] k;
    bit nb;
    k = '0;
    for (int i = 0; i < w; i++) begin
      nb = 1'b0;
      for (int t = 1; t <= 7; t++) if (POLY_M[t-1]) nb = nb ^ hist[hist.size() - t];
      hist.push_back(nb);
      void'(hist.pop_front());
      k[i] = nb;
    end
    return k;
  endfunction

  typedef struct packed {
    logic       sel;
    logic       byp;
    logic       last;
    logic       load;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic sel, byp, last, load, input logic [7:0] din, exp);
    vt.push_back({sel, byp, last, load, din, exp});
  endtask

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  u;
    logic        l;
  } beat_t;
  beat_t src[$], exp_mid[$], exp_out[$];

  // Monitors
  bit         mon_a = 1'b0;
  bit         rt_on = 1'b0;
  int         acc_a;
  logic [7:0] got_a[$];

  always @(posedge aclk) begin
    if (mon_a && ma.tvalid && ma.tready) got_a.push_back(ma.tdata);
    if (mon_a && sa.tvalid && sa.tready) acc_a++;
  end

  always @(posedge aclk) begin
    beat_t e;
    if (rt_on && mid.tvalid && mid.tready) begin
      if (exp_mid.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rt_mid_extra: got beat %0h expected none", mid.tdata);
      end else begin
        e = exp_mid.pop_front();
        check("rt_mid", {mid.tdata, mid.tuser, mid.tlast}, e);
      end
    end
    if (rt_on && mc.tvalid && mc.tready) begin
      if (exp_out.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rt_out_extra: got beat %0h expected none", mc.tdata);
      end else begin
        e = exp_out.pop_front();
        check("rt_out", {mc.tdata, mc.tuser, mc.tlast}, e);
      end
    end
  end

  initial begin
    int   idx, cycles;
    bit   hs;
    int   flen;
    logic [31:0] d, key, m;
    logic [3:0]  u;
    logic        l;

    aresetn  = 1'b0;
    cfg_seed = 7'h7F; cfg_load = 1'b0; cfg_byp = 1'b0;
    c_seed   = 7'h7F; c_load   = 1'b0; c_byp   = 1'b0;
    sa.tvalid = 1'b0; sa.tdata = '0; sa.tuser = '0; sa.tlast = 1'b0; ma.tready = 1'b1;
    sb.tvalid = 1'b0; sb.tdata = '0; sb.tuser = '0; sb.tlast = 1'b0; mb.tready = 1'b1;
    sc.tvalid = 1'b0; sc.tdata = '0; sc.tuser = '0; sc.tlast = 1'b0; mc.tready = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_a", {ma.tvalid, ma.tlast, ma.tuser, ma.tdata, sa.tready}, {1'b0, 1'b0, 4'h0, 8'h00, 1'b1});
    check("rst_b", {mb.tvalid, mb.tlast, mb.tuser, mb.tdata, sb.tready}, {1'b0, 1'b0, 4'h0, 8'h00, 1'b1});
    check("rst_c1", {mid.tvalid, mid.tlast, mid.tuser, mid.tdata, sc.tready}, {1'b0, 1'b0, 4'h0, 32'h0, 1'b1});
    check("rst_c2", {mc.tvalid, mc.tlast, mc.tuser, mc.tdata, mid.tready}, {1'b0, 1'b0, 4'h0, 32'h0, 1'b1});
    aresetn = 1'b1;

    // Instance A (no reseed): keystream, bypass, seed load, tlast continues the sequence
    add(0, 0, 0, 0, 8'h00, 8'h70);
    add(0, 0, 0, 0, 8'h00, 8'h4F);
    add(0, 0, 0, 0, 8'hFF, 8'h6C);
    add(0, 1, 0, 0, 8'hA5, 8'hA5);
    add(0, 0, 0, 0, 8'h00, 8'h40);
    add(0, 0, 0, 1, 8'h00, 8'h64);
    add(0, 0, 0, 0, 8'h00, 8'h70);
    add(0, 0, 0, 0, 8'h00, 8'h4F);
    add(0, 0, 1, 0, 8'h00, 8'h93);
    add(0, 0, 0, 0, 8'h00, 8'h40);
    // Instance B (reseed on tlast), including a bypassed tlast beat
    add(1, 0, 0, 0, 8'h00, 8'h70);
    add(1, 0, 1, 0, 8'h00, 8'h4F);
    add(1, 0, 0, 0, 8'h00, 8'h70);
    add(1, 0, 0, 0, 8'h00, 8'h4F);
    add(1, 1, 1, 0, 8'h3C, 8'h3C);
    add(1, 0, 0, 0, 8'h00, 8'h70);

    foreach (vt[i]) begin
      sa.tvalid = !vt[i].sel; sb.tvalid = vt[i].sel;
      sa.tdata = vt[i].din; sb.tdata = vt[i].din;
      sa.tuser = vt[i].din[3:0]; sb.tuser = vt[i].din[3:0];
      sa.tlast = vt[i].last; sb.tlast = vt[i].last;
      cfg_byp = vt[i].byp; cfg_load = vt[i].load;
      tick();
      cfg_load = 1'b0;
      if (!vt[i].sel)
        check($sformatf("vec%0d", i), {ma.tvalid, ma.tlast, ma.tuser, ma.tdata},
              {1'b1, vt[i].last, vt[i].din[3:0], vt[i].exp});
      else
        check($sformatf("vec%0d", i), {mb.tvalid, mb.tlast, mb.tuser, mb.tdata},
              {1'b1, vt[i].last, vt[i].din[3:0], vt[i].exp});
    end
    sa.tvalid = 1'b0; sb.tvalid = 1'b0; sa.tlast = 1'b0; sb.tlast = 1'b0; cfg_byp = 1'b0;
    tick();

    // Backpressure: two beats absorbed, then ready drops; release drains in order
    aresetn = 1'b0; tick(); aresetn = 1'b1;
    got_a = {}; acc_a = 0; mon_a = 1'b1;
    ma.tready = 1'b0; sa.tvalid = 1'b1; sa.tdata = 8'h00; sa.tuser = 4'h0;
    tick(); tick();
    check("bp_ready_drop", {31'd0, sa.tready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold", {ma.tvalid, ma.tdata, sa.tready}, {1'b1, 8'h70, 1'b0});
    end
    check("bp_accepted", acc_a, 2);
    ma.tready = 1'b1;
    tick();
    check("bp_ready_rise", {sa.tready, ma.tdata}, {1'b1, 8'h4F});
    tick();
    sa.tvalid = 1'b0;
    tick();
    check("bp_count", got_a.size(), 3);
    if (got_a.size() == 3) begin
      check("bp_order0", got_a[0], 8'h70);
      check("bp_order1", got_a[1], 8'h4F);
      check("bp_order2", got_a[2], 8'h93);
    end
    mon_a = 1'b0;

    // Reset with two beats held
    ma.tready = 1'b0; sa.tvalid = 1'b1;
    tick(); tick();
    check("rstmid_pre", {ma.tvalid, sa.tready}, {1'b1, 1'b0});
    aresetn = 1'b0; sa.tvalid = 1'b0;
    tick();
    check("rstmid_flush", {ma.tvalid, sa.tready}, {1'b0, 1'b1});
    aresetn = 1'b1; ma.tready = 1'b1; sa.tvalid = 1'b1; sa.tdata = 8'h00;
    tick();
    check("rstmid_first", {ma.tvalid, ma.tdata}, {1'b1, 8'h70});
    sa.tvalid = 1'b0;
    tick();

    // Random round trip through two chained default instances
    c_seed = 7'($urandom_range(0, 127));
    model_seed(7'h7F);
    while (src.size() < 1000) begin
      flen = $urandom_range(1, 20);
      if (flen > 1000 - src.size()) flen = 1000 - src.size();
      for (int j = 0; j < flen; j++) begin
        d = $urandom; u = 4'($urandom_range(0, 15)); l = (j == flen - 1);
        key = model_key(32);
        m = l ? 32'hFE00_0000 : 32'h0;
        src.push_back({d, u, l});
        exp_mid.push_back({(d ^ key) & ~m, u, l});
        exp_out.push_back({d & ~m, u, l});
        if (l) model_seed(c_seed);
      end
    end
    rt_on = 1'b1; idx = 0; cycles = 0;
    while ((idx < src.size() || exp_out.size() > 0) && cycles < 20000) begin
      if (idx < src.size()) begin
        sc.tvalid = ($urandom_range(0, 3) != 0);
        {sc.tdata, sc.tuser, sc.tlast} = src[idx];
      end else begin
        sc.tvalid = 1'b0;
      end
      mc.tready = ($urandom_range(0, 2) != 0);
      hs = sc.tvalid && sc.tready;
      tick();
      cycles++;
      if (hs) idx++;
    end
    sc.tvalid = 1'b0; mc.tready = 1'b1;
    tick(); tick();
    rt_on = 1'b0;
    check("rt_sent", idx, src.size());
    check("rt_mid_drained", exp_mid.size(), 0);
    check("rt_out_drained", exp_out.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_scrambler.md
Name: lfsr_scrambler

Overview:
- AXI-Stream additive scrambler/descrambler with a fully parametrised Fibonacci LFSR.
- Parametrised in data width, LFSR length/polynomial, tail masking and user width.
- Adds runtime seed load, automatic per-frame reseed, per-beat bypass and a registered-ready skid buffer.
- Sits between framer and mapper on TX; the same block in the RX chain performs descrambling.

Parameters:
WIDTH, 32, data bits per beat; must be >= LFSR_LEN
USER_WIDTH, 4, tuser width, passed through unchanged
LFSR_LEN, 7, LFSR length L (2..32)
POLY, 7'b1001000, tap mask; bit t-1 set means s(n-t) is a tap (default x^7+x^4+1)
SEED, {LFSR_LEN{1'b1}}, LFSR value at reset
RESEED_ON_LAST, 1, 1 = reload LFSR from cfg_seed after every tlast beat
TAIL_BITS, 7, number of MSBs forced to 0 on a tlast beat (0 = off; 0..WIDTH)

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
s_axis_tdata  in  WIDTH  input data
s_axis_tuser  in  USER_WIDTH  sideband
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready (registered)
s_axis_tlast  in  1  end of frame
m_axis_tdata  out  WIDTH  scrambled data
m_axis_tuser  out  USER_WIDTH  delayed tuser
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  delayed tlast
cfg_seed  in  LFSR_LEN  seed for cfg_seed_load and for reseed
cfg_seed_load  in  1  one-cycle pulse: load LFSR from cfg_seed
cfg_bypass  in  1  sampled per input beat: pass data unmodified

Behaviour:
- Reset is synchronous on aresetn low and overrides everything.
  - Outputs after reset: m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, m_axis_tvalid=0, s_axis_tready=1.
  - Reset state: LFSR=SEED, skid buffer empty.
  - Reset mid-frame discards any held beats.
- Sequence definition:
  - s(n) = XOR of s(n-t) over every t in 1..L with POLY[t-1] set.
  - LFSR state r[k] = s(n-L+k), so r[L-1] is the newest bit.
  - For a beat: key bit i = s(n+i) for i = 0..WIDTH-1, computed combinationally and unrolled.
  - After a scrambling beat, r <= key[WIDTH-1:WIDTH-L].
- Data path per accepted beat (s_axis_tvalid & s_axis_tready):
  - Normal: out = in ^ key.
  - If tlast and TAIL_BITS>0: out[WIDTH-1:WIDTH-TAIL_BITS] is forced to 0 after the XOR.
  - cfg_bypass=1: out = in, no masking, LFSR holds.
  - tuser and tlast travel with their beat.
- LFSR update priority, highest first:
  - 1. cfg_seed_load: r <= cfg_seed, regardless of any handshake that cycle. A beat accepted in the same cycle still uses the pre-load key.
  - 2. Accepted beat with tlast and RESEED_ON_LAST=1: r <= cfg_seed.
  - 3. Accepted non-bypass beat: advance as above.
  - 4. Otherwise hold.
- An all-zero seed is legal: the key is 0 and data passes unchanged. No lock-up detection.
- Handshake and buffering (2-entry skid):
  - Latency is 1 cycle, input to m_axis_tvalid.
  - Full throughput of 1 beat/cycle while m_axis_tready=1.
  - s_axis_tready = ~skid_valid, registered. It never depends combinationally on m_axis_tready.
  - Output register loads when empty or when its beat is being taken.
  - If the output register holds an untaken beat and a new beat is accepted, the new beat goes to the skid and s_axis_tready drops next cycle.
  - When the output is taken, the skid moves to the output register and s_axis_tready rises next cycle.
  - Output data, tuser and tlast are stable while m_axis_tvalid=1 and m_axis_tready=0.
  - No beat is dropped or duplicated.
  - The key is computed at acceptance; stalls never alter the keystream.

Test Plan:
- Keystream check: WIDTH=8, TAIL_BITS=0, SEED=7'h7F, RESEED_ON_LAST=0, zero input for 2 beats, m_axis_tready=1 -> out 8'h70 then 8'h4F (the 802.11 sequence 00001110 11110010, LSB first).
- Round trip: two instances in series, default params, 1000 random 32-bit beats, random tvalid/tready, frames of 1..20 beats -> output equals input except the top 7 bits of each tlast beat, which are 0.
- Backpressure: hold m_axis_tready=0 with s_axis_tvalid=1 -> exactly 2 beats accepted, s_axis_tready=0 from the following cycle. Release -> beats emerge in order, unchanged while stalled.
- Reseed: WIDTH=8, cfg_seed=7'h7F, frame of 2 zero beats with tlast on the 2nd -> next frame's first beat is 8'h70 again. Repeat with RESEED_ON_LAST=0 -> the sequence continues instead.
- Seed load and bypass:
  - cfg_seed_load in the same cycle as an accepted beat -> that beat uses the old key; the next beat starts from cfg_seed.
  - A cfg_bypass=1 beat passes through unchanged, and the following beat gets the key the bypassed beat would have used.
- Reset mid-frame: assert aresetn=0 with 2 beats held -> next cycle m_axis_tvalid=0, s_axis_tready=1. First beat after release uses SEED (8'h70 on zero input, WIDTH=8).
